// File: rtl/collatz_seq_driver.sv
// Sequences Collatz seeds through an external compute core and streams one record per seed.
// Define COLLATZ_SEQ_BEST_EN to track the longest orbit of each sweep on best_seed/best_olen.
module collatz_seq_driver (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] seed_base,
    input  logic [15:0] seed_count,
    output logic        core_rst_n,
    output logic [7:0]  core_ui,
    output logic [7:0]  core_uio,
    input  logic        core_busy,
    input  logic [7:0]  core_uo,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [31:0] rec_seed,
    output logic [15:0] rec_olen,
    output logic [15:0] rec_path,
    output logic        active,
    output logic        done,
    output logic [31:0] best_seed,
    output logic [15:0] best_olen
);

    typedef enum logic [3:0] {
        StIdle, StCrst, StLoad, StGo, StWait,
        StRd0, StRd1, StRd2, StRd3, StRd4, StEmit, StFin
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [15:0] count_q, count_d;
    logic [15:0] idx_q, idx_d;
    logic [4:0]  k_q, k_d;
    logic [15:0] olen_q, olen_d;
    logic [15:0] path_q, path_d;
    logic [15:0] idx_inc;

    assign idx_inc  = idx_q + 16'd1;
    assign rec_seed = base_q + {16'd0, idx_q};
    assign rec_olen = olen_q;
    assign rec_path = path_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        k_d     = k_q;
        olen_d  = olen_q;
        path_d  = path_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = seed_base;
                    count_d = seed_count;
                    idx_d   = 16'd0;
                    state_d = (seed_count == 16'd0) ? StFin : StCrst;
                end
            end
            StCrst: begin
                k_d     = 5'd0;
                state_d = StLoad;
            end
            StLoad: begin
                if (k_q == 5'd17) state_d = StGo;
                else k_d = k_q + 5'd1;
            end
            StGo: begin
                k_d     = 5'd0;
                state_d = StWait;
            end
            StWait: begin
                // k_q doubles as the "first WAIT cycle" marker; busy is not yet trustworthy then
                if (k_q == 5'd0) k_d = 5'd1;
                else if (!core_busy) state_d = StRd0;
            end
            StRd0: state_d = StRd1;
            StRd1: begin
                olen_d[7:0] = core_uo;
                state_d     = StRd2;
            end
            StRd2: begin
                olen_d[15:8] = core_uo;
                state_d      = StRd3;
            end
            StRd3: begin
                path_d[7:0] = core_uo;
                state_d     = StRd4;
            end
            StRd4: begin
                path_d[15:8] = core_uo;
                state_d      = StEmit;
            end
            StEmit: begin
                if (rec_ready) begin
                    idx_d   = idx_inc;
                    state_d = (idx_inc == count_q) ? StFin : StCrst;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            base_q  <= 32'd0;
            count_q <= 16'd0;
            idx_q   <= 16'd0;
            k_q     <= 5'd0;
            olen_q  <= 16'd0;
            path_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            olen_q  <= olen_d;
            path_q  <= path_d;
        end
    end

    always_comb begin
        core_rst_n = 1'b1;
        core_ui    = 8'd0;
        core_uio   = 8'd0;
        rec_valid  = 1'b0;
        done       = 1'b0;
        active     = (state_q != StIdle);
        case (state_q)
            StCrst: core_rst_n = 1'b0;
            StLoad: begin
                core_uio = {3'b100, k_q};
                case (k_q)
                    5'd0:    core_ui = rec_seed[7:0];
                    5'd1:    core_ui = rec_seed[15:8];
                    5'd2:    core_ui = rec_seed[23:16];
                    5'd3:    core_ui = rec_seed[31:24];
                    default: core_ui = 8'd0;
                endcase
            end
            StGo:   core_uio = 8'h40;
            StRd0:  core_uio = 8'h00;
            StRd1:  core_uio = 8'h01;
            StRd2:  core_uio = 8'h20;
            StRd3:  core_uio = 8'h21;
            StEmit: rec_valid = 1'b1;
            StFin:  done = 1'b1;
            default: ;
        endcase
        // Reset is synchronous, so the state register may still hold a stale value this cycle
        if (reset) begin
            core_rst_n = 1'b0;
            core_ui    = 8'd0;
            core_uio   = 8'd0;
            rec_valid  = 1'b0;
            done       = 1'b0;
            active     = 1'b0;
        end
    end

`ifdef COLLATZ_SEQ_BEST_EN
    logic [31:0] best_seed_q, best_seed_d;
    logic [15:0] best_olen_q, best_olen_d;

    always_comb begin
        best_seed_d = best_seed_q;
        best_olen_d = best_olen_q;
        if (state_q == StIdle && start) begin
            best_seed_d = 32'd0;
            best_olen_d = 16'd0;
        end else if (state_q == StEmit && rec_ready && olen_q > best_olen_q) begin
            best_seed_d = rec_seed;
            best_olen_d = olen_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            best_seed_q <= 32'd0;
            best_olen_q <= 16'd0;
        end else begin
            best_seed_q <= best_seed_d;
            best_olen_q <= best_olen_d;
        end
    end

    assign best_seed = best_seed_q;
    assign best_olen = best_olen_q;
`else
    assign best_seed = 32'd0;
    assign best_olen = 16'd0;
`endif

endmodule

// File: tb/tb_collatz_seq_driver.sv
// Self-checking bench for collatz_seq_driver with a behavioural compute core and a record scoreboard.
module tb_collatz_seq_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] seed_base;
    logic [15:0] seed_count;
    logic        core_rst_n;
    logic [7:0]  core_ui;
    logic [7:0]  core_uio;
    logic        core_busy;
    logic [7:0]  core_uo;
    logic        rec_valid;
    logic        rec_ready;
    logic [31:0] rec_seed;
    logic [15:0] rec_olen;
    logic [15:0] rec_path;
    logic        active;
    logic        done;
    logic [31:0] best_seed;
    logic [15:0] best_olen;

    always #5 clk = ~clk;

    collatz_seq_driver u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .seed_base  (seed_base),
        .seed_count (seed_count),
        .core_rst_n (core_rst_n),
        .core_ui    (core_ui),
        .core_uio   (core_uio),
        .core_busy  (core_busy),
        .core_uo    (core_uo),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_seed   (rec_seed),
        .rec_olen   (rec_olen),
        .rec_path   (rec_path),
        .active     (active),
        .done       (done),
        .best_seed  (best_seed),
        .best_olen  (best_olen)
    );

    typedef struct {
        logic [31:0] seed;
        logic [15:0] olen;
        logic [15:0] path;
    } rec_t;

    rec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   crst_cyc = 0;
    int   crst_cnt = 0;
    int   done_cnt = 0;
    int   rec_cnt = 0;
    int   hi_bad = 0;
    logic rv_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core convention: orbit length counts steps until the value reaches 2 (or 1), saturating.
    function automatic logic [15:0] ref_olen(input logic [31:0] s);
        longint unsigned v = {32'd0, s};
        int unsigned     n = 0;
        while (v != 1 && v != 2 && n < 65535) begin
            v = v[0] ? (3 * v + 1) : (v >> 1);
            n++;
        end
        return n[15:0];
    endfunction

    function automatic logic [15:0] ref_peak(input logic [31:0] s);
        longint unsigned v = {32'd0, s};
        longint unsigned pk = v;
        int unsigned     n = 0;
        while (v != 1 && v != 2 && n < 65535) begin
            v = v[0] ? (3 * v + 1) : (v >> 1);
            if (v > pk) pk = v;
            n++;
        end
        return pk[15:0];
    endfunction

    // Behavioural compute core
    logic [7:0]  cmem [4];
    logic [15:0] c_olen, c_path;
    logic [7:0]  c_cnt;
    logic [31:0] seed_w;
    assign seed_w = {cmem[3], cmem[2], cmem[1], cmem[0]};

    always @(posedge clk) begin
        if (!core_rst_n) begin
            core_busy <= 1'b0;
            c_olen    <= 16'd0;
            c_path    <= 16'd0;
            c_cnt     <= 8'd0;
        end else begin
            if (core_uio[7]) begin
                if (core_uio[4:0] < 5'd4) cmem[core_uio[1:0]] <= core_ui;
                else if (core_ui != 8'd0) hi_bad <= hi_bad + 1;
            end
            if (core_uio[6]) begin
                c_olen    <= ref_olen(seed_w);
                c_path    <= ref_peak(seed_w);
                c_cnt     <= {5'd0, ref_olen(seed_w) % 16'd8} + 8'd1;
                core_busy <= 1'b1;
            end else if (core_busy) begin
                if (c_cnt == 8'd1) core_busy <= 1'b0;
                else c_cnt <= c_cnt - 8'd1;
            end
        end
        core_uo <= core_uio[5] ? (core_uio[0] ? c_path[15:8] : c_path[7:0])
                               : (core_uio[0] ? c_olen[15:8] : c_olen[7:0]);
    end

    // Output monitor: latency, scoreboard pop, event counts
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                if (!core_rst_n) begin
                    crst_cyc = cyc;
                    crst_cnt++;
                end
                if (rec_valid && !rv_prev) begin
                    if (sb.size() > 0)
                        check_eq("latency", cyc - crst_cyc, 26 + 32'(sb[0].olen % 16'd8) + 1);
                    else
                        check_eq("unexpected_rec", 32'd1, 32'd0);
                end
                if (rec_valid && rec_ready && sb.size() > 0) begin
                    check_eq("rec_seed", rec_seed, sb[0].seed);
                    check_eq("rec_olen", {16'd0, rec_olen}, {16'd0, sb[0].olen});
                    check_eq("rec_path", {16'd0, rec_path}, {16'd0, sb[0].path});
                    void'(sb.pop_front());
                    rec_cnt++;
                end
                if (done) done_cnt++;
                rv_prev = rec_valid;
            end else begin
                rv_prev = 1'b0;
            end
        end
    end

    task automatic push_exp(input logic [31:0] s, input logic [15:0] o, input logic [15:0] p);
        rec_t r;
        r.seed = s;
        r.olen = o;
        r.path = p;
        sb.push_back(r);
    endtask

    task automatic start_sweep(input logic [31:0] b, input logic [15:0] c);
        @(posedge clk);
        #1;
        seed_base  = b;
        seed_count = c;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int   d0, c0, r0;
        bit   seen;
        bit   stable;
        logic [31:0] s_hold;
        logic [15:0] o_hold, p_hold;
        logic [31:0] exp_bs;
        logic [15:0] exp_bo;

        reset      = 1'b1;
        start      = 1'b0;
        seed_base  = 32'd0;
        seed_count = 16'd0;
        rec_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_active", {31'd0, active}, 32'd0);
        check_eq("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
        check_eq("rst_uio", {24'd0, core_uio}, 32'd0);
        check_eq("rst_ui", {24'd0, core_ui}, 32'd0);
        check_eq("rst_valid_done", {30'd0, rec_valid, done}, 32'd0);
        check_eq("rst_best", best_seed | {16'd0, best_olen}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("idle_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check_eq("idle_uio", {24'd0, core_uio}, 32'd0);

        // Seed 27: literal expectations for orbit length and peak
        push_exp(32'd27, 16'd110, 16'd9232);
        d0 = done_cnt;
        start_sweep(32'd27, 16'd1);
        wait_done("done_27", 200);
        check_eq("done_cnt_27", done_cnt - d0, 32'd1);
        check_eq("sb_27", sb.size(), 32'd0);

        // Zero-count sweep
        c0 = crst_cnt;
        r0 = rec_cnt;
        start_sweep(32'd50, 16'd0);
        wait_done("done_cnt0", 3);
        check_eq("crst_cnt0", crst_cnt - c0, 32'd0);
        check_eq("rec_cnt0", rec_cnt - r0, 32'd0);

        // Reset during LOAD byte 9 abandons the sweep
        push_exp(32'd27, ref_olen(32'd27), ref_peak(32'd27));
        d0 = done_cnt;
        r0 = rec_cnt;
        start_sweep(32'd27, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (core_uio[7] && core_uio[4:0] == 5'd9) seen = 1'b1;
        end
        check_eq("saw_load9", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_eq("midrst_active", {31'd0, active}, 32'd0);
        check_eq("midrst_core_rst_n", {31'd0, core_rst_n}, 32'd1);
        check_eq("midrst_uio", {24'd0, core_uio}, 32'd0);
        repeat (40) @(negedge clk);
        check_eq("midrst_no_done", done_cnt - d0, 32'd0);
        check_eq("midrst_no_rec", rec_cnt - r0, 32'd0);

        // Seeds 2,3,4
        push_exp(32'd2, 16'd0, 16'd2);
        push_exp(32'd3, 16'd6, 16'd16);
        push_exp(32'd4, 16'd1, 16'd4);
        start_sweep(32'd2, 16'd3);
        wait_done("done_234", 400);
        check_eq("sb_234", sb.size(), 32'd0);

        // Backpressure: hold rec_ready low for 50 cycles in EMIT
        rec_ready = 1'b0;
        push_exp(32'd100, ref_olen(32'd100), ref_peak(32'd100));
        push_exp(32'd101, ref_olen(32'd101), ref_peak(32'd101));
        c0 = crst_cnt;
        start_sweep(32'd100, 16'd2);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (rec_valid) seen = 1'b1;
        end
        check_eq("stall_valid", {31'd0, seen}, 32'd1);
        s_hold = rec_seed;
        o_hold = rec_olen;
        p_hold = rec_path;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!rec_valid || rec_seed != s_hold || rec_olen != o_hold || rec_path != p_hold)
                stable = 1'b0;
        end
        check_eq("stall_stable", {31'd0, stable}, 32'd1);
        check_eq("stall_no_crst", crst_cnt - c0, 32'd1);
        @(posedge clk);
        #1;
        rec_ready = 1'b1;
        wait_done("done_stall", 300);
        check_eq("sb_stall", sb.size(), 32'd0);

        // Seed wrap to 0 (saturating orbit); a stray start mid-sweep must be ignored
        push_exp(32'hFFFF_FFFF, ref_olen(32'hFFFF_FFFF), ref_peak(32'hFFFF_FFFF));
        push_exp(32'd0, 16'hFFFF, 16'd0);
        start_sweep(32'hFFFF_FFFF, 16'd2);
        repeat (5) @(posedge clk);
        #1;
        seed_base  = 32'd5;
        seed_count = 16'd1;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("done_wrap", 300);
        check_eq("sb_wrap", sb.size(), 32'd0);

        // Seeds 25..27 and best-orbit tracking
        exp_bs = 32'd0;
        exp_bo = 16'd0;
        for (int s = 25; s <= 27; s++) begin
            push_exp(32'(s), ref_olen(32'(s)), ref_peak(32'(s)));
            if (ref_olen(32'(s)) > exp_bo) begin
                exp_bo = ref_olen(32'(s));
                exp_bs = 32'(s);
            end
        end
`ifndef COLLATZ_SEQ_BEST_EN
        exp_bs = 32'd0;
        exp_bo = 16'd0;
`endif
        start_sweep(32'd25, 16'd3);
        wait_done("done_best", 400);
        check_eq("best_seed", best_seed, exp_bs);
        check_eq("best_olen", {16'd0, best_olen}, {16'd0, exp_bo});
        check_eq("sb_best", sb.size(), 32'd0);
        check_eq("hi_bytes_zero", hi_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
